clock_time_ctrl: RTL



---
 rtl/clock_time_ctrl_if.sv | 35 +++
 rtl/clock_time_ctrl.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/clock_time_ctrl_if.sv
// Button and display bus of the digital clock timekeeping controller.
// The display/button side uses the master modport; the controller uses
// the slave modport.
interface clock_time_ctrl_if;
  logic       mode_btn;  // single-cycle pulse, advances the set-mode machine
  logic       inc_btn;   // single-cycle pulse, increments the edited field
  logic [4:0] hours;     // 0..23
  logic [5:0] minutes;   // 0..59
  logic [5:0] seconds;   // 0..59
  logic [1:0] mode;      // 0 RUN, 1 SET_HOUR, 2 SET_MIN
  logic       tick;      // one-cycle timebase pulse, RUN only
  logic       blink;     // flash strobe for the field being edited

  modport master (
    output mode_btn,
    output inc_btn,
    input  hours,
    input  minutes,
    input  seconds,
    input  mode,
    input  tick,
    input  blink
  );

  modport slave (
    input  mode_btn,
    input  inc_btn,
    output hours,
    output minutes,
    output seconds,
    output mode,
    output tick,
    output blink
  );
endinterface

// File: rtl/clock_time_ctrl.sv
// Timekeeping controller for the digital clock.
// A free-running prescaler produces a one-cycle strobe every DIV cycles.
// In RUN the strobe advances hh:mm:ss with full carry in a single edge.
// Two button pulses walk a RUN -> SET_HOUR -> SET_MIN -> RUN machine in
// which inc_btn bumps the edited field. Every output is a flop.
module clock_time_ctrl #(
  parameter int unsigned CLK_HZ  = 10,
  parameter int unsigned TICK_HZ = 1
) (
  input  logic               clk,
  input  logic               rst,
  clock_time_ctrl_if.slave   bus
);

  // Prescaler geometry; DIV must be at least 2 for the strobe to be a pulse.
  localparam int unsigned DIV      = CLK_HZ / TICK_HZ;
  localparam logic [31:0] DIV_LAST = 32'(DIV - 1);
  localparam logic [31:0] DIV_HALF = 32'(DIV / 2);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_SET_HOUR = 2'd1,
    ST_SET_MIN  = 2'd2
  } mode_e;

  // Hour increment with 23 -> 0 wrap.
  function automatic logic [4:0] next_hour(input logic [4:0] h);
    logic [4:0] r;
    if (h == 5'd23) begin
      r = 5'd0;
    end else begin
      r = h + 5'd1;
    end
    return r;
  endfunction

  // Minute/second increment with 59 -> 0 wrap.
  function automatic logic [5:0] next_sixty(input logic [5:0] v);
    logic [5:0] r;
    if (v == 6'd59) begin
      r = 6'd0;
    end else begin
      r = v + 6'd1;
    end
    return r;
  endfunction

  logic [31:0] cnt_q,     cnt_d;
  logic [4:0]  hours_q,   hours_d;
  logic [5:0]  minutes_q, minutes_d;
  logic [5:0]  seconds_q, seconds_d;
  mode_e       mode_q,    mode_d;
  logic        tick_q,    tick_d;
  logic        blink_q,   blink_d;
  logic        strobe_s;

  // Timebase strobe: last count of the prescaler period.
  always_comb begin
    if (cnt_q == DIV_LAST) begin
      strobe_s = 1'b1;
    end else begin
      strobe_s = 1'b0;
    end
  end

  // Next-state logic for prescaler, time fields, mode machine and strobes.
  always_comb begin
    // Prescaler free-runs in every mode and wraps after DIV_LAST.
    if (strobe_s) begin
      cnt_d = 32'd0;
    end else begin
      cnt_d = cnt_q + 32'd1;
    end
    hours_d   = hours_q;
    minutes_d = minutes_q;
    seconds_d = seconds_q;
    mode_d    = mode_q;
    tick_d    = 1'b0;

    case (mode_q)
      ST_RUN: begin
        if (bus.mode_btn) begin
          // Entering set mode drops a coincident strobe and zeroes seconds.
          mode_d    = ST_SET_HOUR;
          seconds_d = 6'd0;
        end else if (strobe_s) begin
          tick_d    = 1'b1;
          seconds_d = next_sixty(seconds_q);
          if (seconds_q == 6'd59) begin
            minutes_d = next_sixty(minutes_q);
            if (minutes_q == 6'd59) begin
              hours_d = next_hour(hours_q);
            end else begin
              hours_d = hours_q;
            end
          end else begin
            minutes_d = minutes_q;
          end
        end else begin
          seconds_d = seconds_q;
        end
      end
      ST_SET_HOUR: begin
        seconds_d = 6'd0;
        if (bus.mode_btn) begin
          mode_d = ST_SET_MIN;
        end else if (bus.inc_btn) begin
          hours_d = next_hour(hours_q);
        end else begin
          hours_d = hours_q;
        end
      end
      ST_SET_MIN: begin
        seconds_d = 6'd0;
        if (bus.mode_btn) begin
          // Restart the prescaler so the first tick lands DIV cycles later.
          mode_d = ST_RUN;
          cnt_d  = 32'd0;
        end else if (bus.inc_btn) begin
          // Minutes wrap without carrying into hours while editing.
          minutes_d = next_sixty(minutes_q);
        end else begin
          minutes_d = minutes_q;
        end
      end
      default: begin
        // Unused encoding: fall back to RUN with a clean seconds field.
        mode_d    = ST_RUN;
        seconds_d = 6'd0;
      end
    endcase

    // Blink is aligned with the registered mode and prescaler it describes.
    if ((mode_d != ST_RUN) && (cnt_d < DIV_HALF)) begin
      blink_d = 1'b1;
    end else begin
      blink_d = 1'b0;
    end
  end

  // State and output registers, cleared asynchronously by rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= 32'd0;
      hours_q   <= 5'd0;
      minutes_q <= 6'd0;
      seconds_q <= 6'd0;
      mode_q    <= ST_RUN;
      tick_q    <= 1'b0;
      blink_q   <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      hours_q   <= hours_d;
      minutes_q <= minutes_d;
      seconds_q <= seconds_d;
      mode_q    <= mode_d;
      tick_q    <= tick_d;
      blink_q   <= blink_d;
    end
  end

  assign bus.hours   = hours_q;
  assign bus.minutes = minutes_q;
  assign bus.seconds = seconds_q;
  assign bus.mode    = mode_q;
  assign bus.tick    = tick_q;
  assign bus.blink   = blink_q;

endmodule
